// File: rtl/btn_pkg.sv
// Shared types and helpers for the button event front end.
package btn_pkg;

    typedef enum logic {IDLE, OFFER} arb_state_t;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_BUTTONS = 16;

    // First set bit strictly after ptr, wrapping at n-1 -> 0; ptr itself is checked last.
    function automatic logic [3:0] next_rr_index(
        input logic [MAX_BUTTONS-1:0] pend,
        input logic [3:0]             ptr,
        input int unsigned            n
    );
        logic [3:0]             pick;
        logic                   found;
        logic [4:0]             cand;
        logic [MAX_BUTTONS-1:0] shifted;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_BUTTONS; k++) begin
            cand = {1'b0, ptr} + 5'(k);
            if (cand >= 5'(n)) begin
                cand = cand - 5'(n);
            end
            shifted = pend >> cand;
            if (!found && (k <= n) && shifted[0]) begin
                pick  = cand[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce counter and change strobe.
// Optional auto-repeat timer when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Raw,
    output logic o_Stable,
    output logic o_Change,
    output logic o_Level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic                   edge_chg;

    assign sync     = sync_q[SYNC_STAGES-1];
    // Strobe is combinational so the arbiter captures it on the same edge stable flips.
    assign edge_chg = (sync != o_Stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q   <= '0;
            cnt      <= '0;
            o_Stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_Raw};
            if (sync == o_Stable) begin
                cnt <= '0;
            end else if (edge_chg) begin
                o_Stable <= sync;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_limit;
    logic             rpt_first;
    logic             rpt_fire;

    assign rpt_limit = rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
    assign rpt_fire  = o_Stable && (rpt_cnt == rpt_limit);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (!o_Stable) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end

    // A release landing on a repeat tick reports the release.
    assign o_Change = edge_chg | rpt_fire;
    assign o_Level  = edge_chg ? sync : 1'b1;
`else
    assign o_Change = edge_chg;
    assign o_Level  = sync;
`endif

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced button front end with one pending event per button and round-robin valid/ready output.
// Auto-repeat events are generated when BTN_AUTOREPEAT_EN is defined.
module button_event_arbiter
    import btn_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250,
    parameter int IDX_W           = $clog2(NUM_BUTTONS)
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [NUM_BUTTONS-1:0] i_Buttons,
    output logic [NUM_BUTTONS-1:0] o_Stable,
    output logic                   o_Event_Valid,
    input  logic                   i_Event_Ready,
    output logic [IDX_W-1:0]       o_Event_Idx,
    output logic                   o_Event_Press,
    output logic                   o_Overflow
);

    arb_state_t             state;
    logic [NUM_BUTTONS-1:0] change;
    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] pend;
    logic [NUM_BUTTONS-1:0] ptype;
    logic [NUM_BUTTONS-1:0] pend_next;
    logic [NUM_BUTTONS-1:0] ptype_next;
    logic [NUM_BUTTONS-1:0] grant_mask;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_en;
    logic                   ovf_hit;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .i_Clk    (i_Clk),
            .i_Rst_n  (i_Rst_n),
            .i_Raw    (i_Buttons[g]),
            .o_Stable (o_Stable[g]),
            .o_Change (change[g]),
            .o_Level  (level[g])
        );
    end

    // A new change on the granted index wins over the grant's clear.
    always_comb begin
        grant_idx  = IDX_W'(next_rr_index(MAX_BUTTONS'(pend), 4'(rr_ptr), NUM_BUTTONS));
        grant_en   = (state == IDLE) && (|pend);
        grant_mask = grant_en ? (NUM_BUTTONS'(1) << grant_idx) : '0;
        pend_next  = (pend & ~grant_mask) | change;
        ovf_hit    = |(pend & ~grant_mask & change);
        ptype_next = ptype;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            if (change[i]) begin
                ptype_next[i] = level[i];
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= IDLE;
            pend          <= '0;
            ptype         <= '0;
            rr_ptr        <= '0;
            o_Event_Valid <= 1'b0;
            o_Event_Idx   <= '0;
            o_Event_Press <= 1'b0;
            o_Overflow    <= 1'b0;
        end else begin
            pend  <= pend_next;
            ptype <= ptype_next;
            if (ovf_hit) begin
                o_Overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        o_Event_Idx   <= grant_idx;
                        o_Event_Press <= ptype[grant_idx];
                        rr_ptr        <= grant_idx;
                        o_Event_Valid <= 1'b1;
                        state         <= OFFER;
                    end
                end
                OFFER: begin
                    if (i_Event_Ready) begin
                        o_Event_Valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed scoreboard bench for button_event_arbiter (4 buttons, 4-cycle debounce, repeat 20/8).
// Long-hold scenarios are skipped when BTN_AUTOREPEAT_EN is defined, since holds would trigger repeats.
`timescale 1ns/1ps
module tb_button_event_arbiter;

    typedef struct {
        logic [1:0] idx;
        logic       press;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] buttons;
    logic       ready;
    logic [3:0] stable;
    logic       valid;
    logic [1:0] idx;
    logic       press;
    logic       overflow;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_event_arbiter #(
        .NUM_BUTTONS     (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Buttons     (buttons),
        .o_Stable      (stable),
        .o_Event_Valid (valid),
        .i_Event_Ready (ready),
        .o_Event_Idx   (idx),
        .o_Event_Press (press),
        .o_Overflow    (overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int i, input int p, input int gap);
        exp_t e;
        e.idx   = 2'(i);
        e.press = p[0];
        e.gap   = gap;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d events outstanding, required 0", sb.size());
            sb.delete();
        end
        tick(4);
    endtask

    // Monitor: transfers are seen at the negedge before the edge that completes them.
    initial begin : monitor
        exp_t       e;
        logic       pv;
        logic       pr;
        logic [1:0] pi;
        logic       pp;
        int         last_xfer;
        pv = 1'b0;
        pr = 1'b0;
        pi = '0;
        pp = 1'b0;
        last_xfer = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("stall_valid_hold", valid, 1);
                    check("stall_idx_hold", idx, pi);
                    check("stall_press_hold", press, pp);
                end
                if (valid && ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: got idx=%0d press=%0d, required none", idx, press);
                    end else begin
                        e = sb.pop_front();
                        check("event_idx", idx, e.idx);
                        check("event_press", press, e.press);
                        if (e.gap > 0) begin
                            check("event_gap", cyc - last_xfer, e.gap);
                        end
                    end
                    last_xfer = cyc;
                end
                pv = valid;
                pr = ready;
                pi = idx;
                pp = press;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin : stimulus
        int stale;
        rst_n   = 1'b1;
        buttons = '0;
        ready   = 1'b0;
        #2;
        rst_n = 1'b0;
        tick(3);
        check("reset_stable", stable, 0);
        check("reset_valid", valid, 0);
        check("reset_idx", idx, 0);
        check("reset_press", press, 0);
        check("reset_overflow", overflow, 0);
        rst_n = 1'b1;
        ready = 1'b1;

`ifndef BTN_AUTOREPEAT_EN
        // Clean press on button 1: stable after the 6th edge.
        buttons[1] = 1'b1;
        expect_ev(1, 1, 0);
        tick(5);
        check("clean_stable_edge5", stable[1], 0);
        tick(1);
        check("clean_stable_edge6", stable[1], 1);
        wait_drain(20);

        // Bounce on button 0: 3 clocks high, 2 low, then hold.
        expect_ev(0, 1, 0);
        for (int e = 1; e <= 12; e++) begin
            buttons[0] = (e <= 3 || e >= 6);
            tick(1);
            check("bounce_stable", stable[0], (e >= 11) ? 1 : 0);
        end
        wait_drain(20);

        // Release 0 and 1 together; pointer at 0 so 1 goes first.
        buttons[1:0] = 2'b00;
        expect_ev(1, 0, 0);
        expect_ev(0, 0, 2);
        wait_drain(30);

        // Press 3 alone to park the pointer on 3.
        buttons[3] = 1'b1;
        expect_ev(3, 1, 0);
        wait_drain(20);

        // Simultaneous changes on 0, 2, 3.
        buttons = 4'b0101;
        expect_ev(0, 1, 0);
        expect_ev(2, 1, 2);
        expect_ev(3, 0, 2);
        wait_drain(30);

        // Simultaneous 0/3 change with pointer on 3.
        buttons = 4'b1100;
        expect_ev(0, 0, 0);
        expect_ev(3, 1, 2);
        wait_drain(30);

        buttons = 4'b0000;
        expect_ev(2, 0, 0);
        expect_ev(3, 0, 2);
        wait_drain(30);
`endif

        // Hold button 3 for 40 clocks of stable level.
        buttons[3] = 1'b1;
        expect_ev(3, 1, 0);
`ifdef BTN_AUTOREPEAT_EN
        expect_ev(3, 1, 20);
        expect_ev(3, 1, 8);
        expect_ev(3, 1, 8);
`endif
        expect_ev(3, 0, 0);
        tick(6);
        check("hold_stable_rise", stable[3], 1);
        tick(34);
        buttons[3] = 1'b0;
        tick(5);
        check("hold_stable_still_high", stable[3], 1);
        tick(1);
        check("hold_stable_fall", stable[3], 0);
        wait_drain(40);

        // Backpressure on button 2 with two overwrites of its pending event.
        ready = 1'b0;
        buttons[2] = 1'b1;
        tick(10);
        check("bp_valid", valid, 1);
        check("bp_idx", idx, 2);
        check("bp_press", press, 1);
        buttons[2] = 1'b0;
        tick(10);
        check("bp_no_overflow_yet", overflow, 0);
        buttons[2] = 1'b1;
        tick(10);
        check("bp_overflow_set", overflow, 1);
        buttons[2] = 1'b0;
        tick(10);
        check("bp_idx_held", idx, 2);
        check("bp_press_held", press, 1);
        expect_ev(2, 1, 0);
        expect_ev(2, 0, 2);
        ready = 1'b1;
        wait_drain(20);
        check("bp_overflow_sticky", overflow, 1);

        // Asynchronous reset in the middle of an offer.
        ready = 1'b0;
        buttons[1] = 1'b1;
        tick(10);
        check("rst_offer_valid", valid, 1);
        buttons = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", valid, 0);
        check("rst_async_stable", stable, 0);
        check("rst_async_overflow", overflow, 0);
        tick(2);
        rst_n = 1'b1;
        ready = 1'b1;
        stale = 0;
        repeat (20) begin
            tick(1);
            if (valid) stale++;
        end
        check("rst_no_stale_event", stale, 0);
        check("final_queue_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
